// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the iterative restoring divider.
//   - DIV_WIDTH : default operand/result width
//   - state_t   : controller state encoding (IDLE, CALC, DONE)
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring-division iteration, purely combinational.
//   The concatenation {rem, quot} is shifted left by one bit. The divisor is
//   subtracted from the widened partial remainder when that remainder is
//   greater than or equal to the divisor, and the quotient LSB records the
//   outcome.
//
//   Ports
//     rem_i     [WIDTH-1:0]  partial remainder before this step
//     quot_i    [WIDTH-1:0]  dividend bits still to shift in, plus the
//                            quotient bits built so far
//     divisor_i [WIDTH-1:0]  captured divisor
//     rem_o     [WIDTH-1:0]  partial remainder after this step
//     quot_o    [WIDTH-1:0]  quotient register after this step
//
//   WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // The shifted partial remainder needs WIDTH+1 bits. The incoming rem_i is
  // always below the divisor, so the shifted value is below 2*divisor, and the
  // compare/subtract therefore cannot overflow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvsr_ext;
  logic [WIDTH:0] diff;
  logic           ge;
  logic           unused_diff_msb;

  assign shifted  = {rem_i, quot_i[WIDTH-1]};
  assign dvsr_ext = {1'b0, divisor_i};
  assign ge       = (shifted >= dvsr_ext);
  assign diff     = shifted - dvsr_ext;

  // After a successful subtract, the difference is below the divisor, so its
  // MSB is always zero. Without a subtract, shifted[WIDTH] is zero for the
  // same reason. When the divisor is 0, no bit from the top can reach
  // position WIDTH within WIDTH steps.
  assign rem_o           = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_o          = {quot_i[WIDTH-2:0], ge};
  assign unused_diff_msb = diff[WIDTH];

endmodule : div_step

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Multi-cycle unsigned restoring divider. Each clock in CALC performs one
//   quotient bit, MSB first.
//
//   Handshake: a start pulse is accepted only on a rising edge where the
//   controller is IDLE. The operands are captured on that edge. busy is high
//   for exactly WIDTH cycles while CALC runs. done is then high for a single
//   cycle, which is cycle WIDTH+1 counting the cycle after the accepting edge
//   as cycle 1. A start seen in CALC or DONE is dropped; it is not queued.
//   result/remainder/div_by_zero are registered. They change only on the edge
//   that enters DONE, and they hold until the next completion or until reset.
//
//   Ports
//     clk           rising-edge clock
//     rst           asynchronous, active-high reset
//     start         division request
//     dividend      numerator (captured on accept)
//     divisor       denominator (captured on accept)
//     busy          high in CALC
//     done          one-cycle completion pulse (DONE state)
//     result        quotient; all ones when the divisor was 0
//     remainder     remainder; equals the dividend when the divisor was 0
//     div_by_zero   the last completed division had divisor 0
//     dbg_state     current controller state, for observation
// -----------------------------------------------------------------------------
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quot;
  logic             accept;
  logic             last_step;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  assign accept    = (state_q == IDLE) && start;
  // cnt_q numbers the step in progress. The step with cnt_q == WIDTH-1
  // produces the final quotient bit, so that step's edge also enters DONE.
  assign last_step = (state_q == CALC) && (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == CALC);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (accept) begin
      // The quotient register starts out holding the dividend. Its bits shift
      // out of the top into the remainder as quotient bits shift in below.
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend;
      dvsr_d = divisor;
      dbz_d  = 1'b0;
    end else if (state_q == CALC) begin
      cnt_d  = cnt_q + CW'(1);
      rem_d  = step_rem;
      quot_d = step_quot;
      if (last_step) begin
        // With divisor 0, the remainder is never reduced, so every quotient
        // bit becomes 1 and the remainder ends up equal to the dividend.
        result_d    = step_quot;
        remainder_d = step_rem;
        dbz_d       = (dvsr_q == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign result      = result_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : divider

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider (WIDTH 16). The expected quotient and
//   remainder come from plain '/' and '%' arithmetic, with divide-by-zero
//   handled as a special case.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {div_by_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a start pulse that is sampled on the next rising edge. After that
  // edge, the operand inputs are scrambled to confirm that they were captured.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Waits for done. Call this at 1 time unit after an edge, with 'skip' edges
  // already elapsed since the accepting edge. cyc counts the cycle following
  // the accepting edge as cycle 1.
  task automatic wait_done(input int skip, output int cyc, output logic [2*W:0] obs,
                           output bit held, output bit timed_out);
    logic [W-1:0] r0;
    logic [W-1:0] m0;
    r0        = result;
    m0        = remainder;
    held      = 1'b1;
    timed_out = 1'b1;
    cyc       = 0;
    obs       = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        cyc       = n + skip + 1;
        obs       = {div_by_zero, result, remainder};
        timed_out = 1'b0;
        break;
      end
      if (result !== r0 || remainder !== m0) held = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, result, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b dbz=%0b res=%0h rem=%0h, expected all 0",
               busy, done, div_by_zero, result, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // A single complete division, with every observable aspect of it checked.
  task automatic check_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int           cyc;
    logic [2*W:0] obs;
    logic [2*W:0] exp;
    bit           held;
    bit           to;
    start_div(a, b);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %0b expected 1 after accept", name, busy);
    end
    wait_done(0, cyc, obs, held, to);
    exp = exp_q.pop_front();
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      if (cyc != W + 1) begin
        errors++;
        $display("FAIL %s latency: got cycle %0d expected %0d", name, cyc, W + 1);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s value: %0d/%0d got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                 name, a, b, obs[2*W-1:W], obs[W-1:0], obs[2*W], exp[2*W-1:W], exp[W-1:0], exp[2*W]);
      end
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s held: outputs changed before done", name);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: got done=%0b busy=%0b expected 0 0 one cycle after done", name, done, busy);
    end
  endtask

  task automatic test_directed();
    check_one("d28_11",   16'd28,    16'd11);
    check_one("d65535_1", 16'd65535, 16'd1);
    check_one("d5_9",     16'd5,     16'd9);
    check_one("d100_0",   16'd100,   16'd0);
    check_one("d0_7",     16'd0,     16'd7);
    check_one("d9_9",     16'd9,     16'd9);
  endtask

  // The second start is driven on the first IDLE edge after DONE.
  task automatic test_back_to_back();
    check_one("b2b_36_6", 16'd36, 16'd6);
    check_one("b2b_37_6", 16'd37, 16'd6);
  endtask

  task automatic test_ignored_start();
    int           cyc;
    int           extra_done;
    logic [2*W:0] obs;
    logic [2*W:0] exp;
    bit           held;
    bit           to;
    start_div(16'd28, 16'd11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, cyc, obs, held, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || cyc != W + 1 || obs !== exp) begin
      errors++;
      $display("FAIL ign_busy: timeout=%0b cyc=%0d q=%0d r=%0d, expected cycle %0d q=%0d r=%0d",
               to, cyc, obs[2*W-1:W], obs[W-1:0], W + 1, exp[2*W-1:W], exp[W-1:0]);
    end
    // start while in DONE must not launch a new division.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ign_done: got busy=%0b done=%0b expected 0 0", busy, done);
    end
    extra_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0 || result !== 16'd2 || remainder !== 16'd6) begin
      errors++;
      $display("FAIL ign_once: got %0d extra active cycles, q=%0d r=%0d, expected 0 and q=2 r=6",
               extra_done, result, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int           cyc;
    int           seen;
    logic [2*W:0] obs;
    bit           held;
    bit           to;
    // Abort during CALC (cycle 8).
    start_div(16'd1234, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, result, remainder} !== '0) begin
      errors++;
      $display("FAIL abort_calc: got busy=%0b done=%0b dbz=%0b res=%0d rem=%0d expected all 0",
               busy, done, div_by_zero, result, remainder);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_nodone: got %0d done cycles expected 0", seen);
    end
    check_one("post_abort_37_6", 16'd37, 16'd6);
    // Abort while done is high.
    start_div(16'd28, 16'd11);
    wait_done(0, cyc, obs, held, to);
    void'(exp_q.pop_front());
    rst = 1'b1;
    #1;
    checks++;
    if (to || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL abort_done: timeout=%0b done=%0b res=%0d expected done 0 res 0", to, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    check_one("post_abort2_100_4", 16'd100, 16'd4);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel <= 3) b = W'($urandom_range(1, 15));
      else               b = W'($urandom_range(1, 65535));
      check_one("rand", a, b);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_divider
